// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds the FSM state encoding, the control bundle and the register-match helper.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_DROP      = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } ctrl_bundle_t;

  // Canned control patterns, ordered as the struct fields above
  localparam ctrl_bundle_t CTRL_FLOW     = ctrl_bundle_t'(8'b1111_1000);
  localparam ctrl_bundle_t CTRL_FREEZE   = ctrl_bundle_t'(8'b0000_1001);
  localparam ctrl_bundle_t CTRL_RELEASE  = ctrl_bundle_t'(8'b0001_1000);
  localparam ctrl_bundle_t CTRL_STALL    = ctrl_bundle_t'(8'b0011_1010);
  localparam ctrl_bundle_t CTRL_REDIRECT = ctrl_bundle_t'(8'b1111_1100);
  localparam ctrl_bundle_t CTRL_FETCH    = ctrl_bundle_t'(8'b0111_1100);

  // A producer only matters when it writes a real register the consumer reads
  function automatic logic reg_match(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] src,
                                     input logic             use_src);
    return use_src && (rd != REG_ZERO) && (rd == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stage enables/flushes out.
// Optional counter outputs exist only when HAZARD_PERF_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic       use_rs1_ID;
  logic       use_rs2_ID;
  logic       branch_ID;
  logic       redirect_ID;
  logic [4:0] rd_EX;
  logic       RegWrite_EX;
  logic       MemRead_EX;
  logic [4:0] rd_MEM;
  logic       MemRead_MEM;
  logic       dmem_req_MEM;
  logic       dmem_ready;
  logic       imem_ready;

  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       memwb_flush;
  logic [1:0] state_o;
  logic       err_timeout;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_data_stall;
  logic [CNT_W-1:0] perf_dmem_stall;
  logic [CNT_W-1:0] perf_flush;
`endif

  modport master (
    input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, branch_ID, redirect_ID,
    input  rd_EX, RegWrite_EX, MemRead_EX, rd_MEM, MemRead_MEM,
    input  dmem_req_MEM, dmem_ready, imem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, memwb_flush, state_o, err_timeout
`ifdef HAZARD_PERF_EN
    , output perf_data_stall, perf_dmem_stall, perf_flush
`endif
  );

  modport slave (
    output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, branch_ID, redirect_ID,
    output rd_EX, RegWrite_EX, MemRead_EX, rd_MEM, MemRead_MEM,
    output dmem_req_MEM, dmem_ready, imem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, memwb_flush, state_o, err_timeout
`ifdef HAZARD_PERF_EN
    , input perf_data_stall, perf_dmem_stall, perf_flush
`endif
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational detection of load-use (EX->ID) and load-to-branch (MEM->ID) hazards.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic             use_rs1_i,
  input  logic             use_rs2_i,
  input  logic             branch_i,
  input  logic [REG_W-1:0] rd_ex_i,
  input  logic             mem_read_ex_i,
  input  logic [REG_W-1:0] rd_mem_i,
  input  logic             mem_read_mem_i,
  output logic             lu_o,
  output logic             lb_o
);

  assign lu_o = mem_read_ex_i &
                (reg_match(rd_ex_i, rs1_i, use_rs1_i) | reg_match(rd_ex_i, rs2_i, use_rs2_i));

  // Branch operands are consumed in ID, so a load still in MEM is one cycle too late
  assign lb_o = branch_i & mem_read_mem_i &
                (reg_match(rd_mem_i, rs1_i, use_rs1_i) | reg_match(rd_mem_i, rs2_i, use_rs2_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (RUN / DMEM_WAIT / DROP).
// Define HAZARD_PERF_EN to add saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  pipeline_hazard_ctrl_if.master bus
);

  localparam int unsigned WCNT_W = (DMEM_TIMEOUT > 2) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(DMEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  ctrl_bundle_t      ctrl;
  logic              lu, lb, data_stall, dm;

  hazard_detect u_hazard_detect (
    .rs1_i          (bus.rs1_ID),
    .rs2_i          (bus.rs2_ID),
    .use_rs1_i      (bus.use_rs1_ID),
    .use_rs2_i      (bus.use_rs2_ID),
    .branch_i       (bus.branch_ID),
    .rd_ex_i        (bus.rd_EX),
    .mem_read_ex_i  (bus.MemRead_EX),
    .rd_mem_i       (bus.rd_MEM),
    .mem_read_mem_i (bus.MemRead_MEM),
    .lu_o           (lu),
    .lb_o           (lb)
  );

  assign data_stall = lu | lb;
  assign dm         = bus.dmem_req_MEM & ~bus.dmem_ready;

  // State register, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      ST_RUN: begin
        if (dm) begin
          state_d    = ST_DMEM_WAIT;
          wait_cnt_d = '0;
        end else if (!data_stall && bus.redirect_ID && !bus.imem_ready) begin
          state_d = ST_DROP;
        end
      end
      ST_DMEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_DROP: begin
        if (!dm && bus.imem_ready) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Mealy control outputs; reset forces free flow
  always_comb begin
    ctrl = CTRL_FLOW;
    if (rstn) begin
      unique case (state_q)
        ST_RUN: begin
          if (dm)                    ctrl = CTRL_FREEZE;
          else if (data_stall)       ctrl = CTRL_STALL;
          else if (bus.redirect_ID)  ctrl = CTRL_REDIRECT;
          else if (!bus.imem_ready)  ctrl = CTRL_FETCH;
        end
        ST_DMEM_WAIT: ctrl = bus.dmem_ready ? CTRL_RELEASE : CTRL_FREEZE;
        ST_DROP: begin
          if (dm) begin
            ctrl = CTRL_FREEZE;
          end else begin
            // The returning stale word is bubbled; its arrival releases the next fetch
            ctrl       = CTRL_FETCH;
            ctrl.pc_en = bus.imem_ready;
          end
        end
        default: ctrl = CTRL_FLOW;
      endcase
    end
  end

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.memwb_en    = ctrl.memwb_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.memwb_flush = ctrl.memwb_flush;
  assign bus.state_o     = state_q;
  assign bus.err_timeout = err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_data_q, perf_dmem_q, perf_flush_q;
  logic             ev_data, ev_dmem, ev_flush;

  assign ev_data  = (state_q == ST_RUN) & ~dm & data_stall;
  assign ev_dmem  = (state_q == ST_DMEM_WAIT) ? ~bus.dmem_ready : dm;
  assign ev_flush = ctrl.ifid_flush;

  // Saturating event counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_data_q  <= '0;
      perf_dmem_q  <= '0;
      perf_flush_q <= '0;
    end else begin
      if (ev_data  && !(&perf_data_q))  perf_data_q  <= perf_data_q  + CNT_W'(1);
      if (ev_dmem  && !(&perf_dmem_q))  perf_dmem_q  <= perf_dmem_q  + CNT_W'(1);
      if (ev_flush && !(&perf_flush_q)) perf_flush_q <= perf_flush_q + CNT_W'(1);
    end
  end

  assign bus.perf_data_stall = perf_data_q;
  assign bus.perf_dmem_stall = perf_dmem_q;
  assign bus.perf_flush      = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a rule-level model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TMO = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();

  pipeline_hazard_ctrl #(.DMEM_TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: "waiting on dmem", "dropping a stale fetch", sticky error, not-ready count
  bit m_wait = 1'b0;
  bit m_drop = 1'b0;
  bit m_err  = 1'b0;
  int m_nr   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit reads(input logic [4:0] rd, input logic [4:0] src, input logic u);
    return u && (rd != 5'd0) && (rd == src);
  endfunction

  function automatic bit data_haz();
    bit lu, lb;
    lu = bus.MemRead_EX && (reads(bus.rd_EX, bus.rs1_ID, bus.use_rs1_ID) ||
                            reads(bus.rd_EX, bus.rs2_ID, bus.use_rs2_ID));
    lb = bus.branch_ID && bus.MemRead_MEM &&
         (reads(bus.rd_MEM, bus.rs1_ID, bus.use_rs1_ID) ||
          reads(bus.rd_MEM, bus.rs2_ID, bus.use_rs2_ID));
    return lu || lb;
  endfunction

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, memwb_flush}
  function automatic logic [7:0] act_ctrl();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.memwb_flush};
  endfunction

  function automatic logic [7:0] exp_ctrl();
    bit dm;
    dm = bus.dmem_req_MEM && !bus.dmem_ready;
    if (!rstn)              return 8'b1111_1000;
    if (m_wait)             return bus.dmem_ready ? 8'b0001_1000 : 8'b0000_1001;
    if (dm)                 return 8'b0000_1001;
    if (m_drop)             return {bus.imem_ready, 7'b111_1100};
    if (data_haz())         return 8'b0011_1010;
    if (bus.redirect_ID)    return 8'b1111_1100;
    if (!bus.imem_ready)    return 8'b0111_1100;
    return 8'b1111_1000;
  endfunction

  function automatic logic [1:0] exp_state();
    if (!rstn)  return 2'd0;
    if (m_wait) return 2'd1;
    if (m_drop) return 2'd2;
    return 2'd0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_wait <= 1'b0;
      m_drop <= 1'b0;
      m_err  <= 1'b0;
      m_nr   <= 0;
    end else if (m_wait) begin
      if (bus.dmem_ready) begin
        m_wait <= 1'b0;
      end else begin
        m_nr <= m_nr + 1;
        if (m_nr + 1 >= int'(TMO)) m_err <= 1'b1;
      end
    end else if (bus.dmem_req_MEM && !bus.dmem_ready) begin
      if (!m_drop) begin
        m_wait <= 1'b1;
        m_nr   <= 0;
      end
    end else if (m_drop) begin
      if (bus.imem_ready) m_drop <= 1'b0;
    end else if (!data_haz() && bus.redirect_ID && !bus.imem_ready) begin
      m_drop <= 1'b1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("ctrl",  32'(act_ctrl()),      32'(exp_ctrl()));
    check("state", 32'(bus.state_o),     32'(exp_state()));
    check("err",   32'(bus.err_timeout), 32'(m_err));
  end

  task automatic set_idle();
    bus.rs1_ID = 5'd0;  bus.rs2_ID = 5'd0;
    bus.use_rs1_ID = 1'b0; bus.use_rs2_ID = 1'b0;
    bus.branch_ID = 1'b0;  bus.redirect_ID = 1'b0;
    bus.rd_EX = 5'd0;  bus.RegWrite_EX = 1'b0; bus.MemRead_EX = 1'b0;
    bus.rd_MEM = 5'd0; bus.MemRead_MEM = 1'b0;
    bus.dmem_req_MEM = 1'b0; bus.dmem_ready = 1'b1; bus.imem_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [7:0] c, input logic [1:0] st);
    @(negedge clk);
    #1;
    check({name, "_ctrl"},  32'(act_ctrl()),  32'(c));
    check({name, "_state"}, 32'(bus.state_o), 32'(st));
  endtask

  task automatic rand_drive();
    if (!rstn) rstn = 1'b1;
    else if ($urandom_range(0, 399) == 0) rstn = 1'b0;
    bus.rs1_ID      = 5'($urandom_range(0, 3));
    bus.rs2_ID      = 5'($urandom_range(0, 3));
    bus.rd_EX       = 5'($urandom_range(0, 3));
    bus.rd_MEM      = 5'($urandom_range(0, 3));
    bus.use_rs1_ID  = 1'($urandom_range(0, 1));
    bus.use_rs2_ID  = 1'($urandom_range(0, 1));
    bus.branch_ID   = ($urandom_range(0, 3) == 0);
    bus.MemRead_EX  = ($urandom_range(0, 2) == 0);
    bus.RegWrite_EX = bus.MemRead_EX | 1'($urandom_range(0, 1));
    bus.MemRead_MEM = ($urandom_range(0, 2) == 0);
    bus.redirect_ID = ($urandom_range(0, 5) == 0);
    bus.imem_ready  = ($urandom_range(0, 3) != 0);
    if (m_wait) begin
      bus.dmem_req_MEM = 1'b1;
      bus.dmem_ready   = ($urandom_range(0, 4) == 0);
    end else begin
      bus.dmem_req_MEM = ($urandom_range(0, 3) == 0);
      bus.dmem_ready   = ($urandom_range(0, 1) == 0);
    end
    // ID holds a bubble while a stale fetch is being dropped
    if (m_drop) begin
      bus.redirect_ID = 1'b0;
      bus.use_rs1_ID  = 1'b0;
      bus.use_rs2_ID  = 1'b0;
    end
  endtask

  initial begin
    set_idle();
    bus.dmem_req_MEM = 1'b1;
    bus.dmem_ready   = 1'b0;
    bus.redirect_ID  = 1'b1;
    #2;
    check("rst_ctrl",  32'(act_ctrl()),      32'h0000_00F8);
    check("rst_state", 32'(bus.state_o),     32'd0);
    check("rst_err",   32'(bus.err_timeout), 32'd0);
    tick(); set_idle(); rstn = 1'b1;

    // load-use: one stall cycle
    tick(); set_idle();
    bus.MemRead_EX = 1'b1; bus.RegWrite_EX = 1'b1; bus.rd_EX = 5'd5;
    bus.use_rs1_ID = 1'b1; bus.rs1_ID = 5'd5;
    lit("lu_stall", 8'h3A, 2'd0);
    tick(); set_idle();
    bus.MemRead_MEM = 1'b1; bus.rd_MEM = 5'd5; bus.use_rs1_ID = 1'b1; bus.rs1_ID = 5'd5;
    lit("lu_after", 8'hF8, 2'd0);

    // load feeding branch: two stalls with redirect ignored, then redirect taken
    tick(); set_idle();
    bus.MemRead_EX = 1'b1; bus.RegWrite_EX = 1'b1; bus.rd_EX = 5'd7;
    bus.branch_ID = 1'b1; bus.use_rs2_ID = 1'b1; bus.rs2_ID = 5'd7; bus.redirect_ID = 1'b1;
    lit("lb_stall1", 8'h3A, 2'd0);
    tick(); set_idle();
    bus.MemRead_MEM = 1'b1; bus.rd_MEM = 5'd7;
    bus.branch_ID = 1'b1; bus.use_rs2_ID = 1'b1; bus.rs2_ID = 5'd7; bus.redirect_ID = 1'b1;
    lit("lb_stall2", 8'h3A, 2'd0);
    tick(); set_idle();
    bus.branch_ID = 1'b1; bus.use_rs2_ID = 1'b1; bus.rs2_ID = 5'd7; bus.redirect_ID = 1'b1;
    lit("lb_resolve", 8'hFC, 2'd0);

    // x0 never creates a hazard
    tick(); set_idle();
    bus.MemRead_EX = 1'b1; bus.rd_EX = 5'd0; bus.use_rs1_ID = 1'b1; bus.rs1_ID = 5'd0;
    lit("x0_nostall", 8'hF8, 2'd0);

    // data-memory wait, completing on the third wait cycle
    tick(); set_idle(); bus.dmem_req_MEM = 1'b1; bus.dmem_ready = 1'b0;
    lit("dm_enter", 8'h09, 2'd0);
    repeat (2) begin tick(); lit("dm_wait", 8'h09, 2'd1); end
    tick(); bus.dmem_ready = 1'b1;
    lit("dm_ready", 8'h18, 2'd1);
    tick(); set_idle();
    lit("dm_done", 8'hF8, 2'd0);

    // timeout: flag appears after the fourth not-ready wait cycle and sticks
    tick(); set_idle(); bus.dmem_req_MEM = 1'b1; bus.dmem_ready = 1'b0;
    lit("tmo_enter", 8'h09, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); lit("tmo_wait", 8'h09, 2'd1);
      check("tmo_clear", 32'(bus.err_timeout), 32'd0);
    end
    tick(); lit("tmo_wait5", 8'h09, 2'd1);
    check("tmo_set", 32'(bus.err_timeout), 32'd1);
    tick(); bus.dmem_ready = 1'b1;
    lit("tmo_ready", 8'h18, 2'd1);
    tick(); set_idle();
    lit("tmo_done", 8'hF8, 2'd0);
    check("tmo_sticky", 32'(bus.err_timeout), 32'd1);

    // asynchronous reset during a wait
    tick(); set_idle(); bus.dmem_req_MEM = 1'b1; bus.dmem_ready = 1'b0;
    lit("rw_enter", 8'h09, 2'd0);
    tick(); lit("rw_wait", 8'h09, 2'd1);
    #2; rstn = 1'b0; #1;
    check("rw_ctrl",  32'(act_ctrl()),      32'h0000_00F8);
    check("rw_state", 32'(bus.state_o),     32'd0);
    check("rw_err",   32'(bus.err_timeout), 32'd0);
    tick(); set_idle(); rstn = 1'b1;
    lit("rw_after", 8'hF8, 2'd0);

    // redirect while a fetch is outstanding, then drop the stale word
    tick(); set_idle(); bus.redirect_ID = 1'b1; bus.imem_ready = 1'b0;
    lit("redir", 8'hFC, 2'd0);
    tick(); set_idle(); bus.imem_ready = 1'b0;
    lit("drop_hold", 8'h7C, 2'd2);
    tick(); set_idle();
    lit("drop_discard", 8'hFC, 2'd2);
    tick(); set_idle();
    lit("drop_done", 8'hF8, 2'd0);

    // plain fetch stall
    tick(); set_idle(); bus.imem_ready = 1'b0;
    lit("fetch_stall", 8'h7C, 2'd0);

    repeat (4000) begin
      tick();
      rand_drive();
    end
    tick(); set_idle(); rstn = 1'b1;
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
